// File: rtl/tick_pwm.sv
// tick_pwm: multi-channel PWM generator stepped by the timer's period tick.
// One shared step counter runs 0..P-1 (P = 2^R - 1). Each channel compares the
// counter against its active duty. New duties land in a shadow register over a
// valid/ready handshake and become active only at a period boundary, or right
// away while the generator is parked, so outputs never glitch mid-period.
module tick_pwm #(
  parameter int unsigned RESOLUTION_BITS = 8,
  parameter int unsigned NB_CHANNELS     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   tick,
  input  logic                                   enable,
  input  logic [NB_CHANNELS*RESOLUTION_BITS-1:0] duty_in,
  input  logic                                   duty_valid,
  output logic                                   duty_ready,
  output logic [NB_CHANNELS-1:0]                 pwm_out,
  output logic                                   cycle_start
);

  localparam int unsigned R = RESOLUTION_BITS;
  localparam int unsigned W = NB_CHANNELS * RESOLUTION_BITS;

  // Last counter value in a period: P-1 = 2^R - 2 (all ones except the LSB).
  localparam logic [R-1:0] LAST = {{(R-1){1'b1}}, 1'b0};

  logic [R-1:0]             cnt;
  logic [W-1:0]             active;
  logic [W-1:0]             pending;
  logic                     pending_full;
  logic                     enable_prev;

  logic                     step;
  logic                     wrap;
  logic                     accept;
  logic                     load;
  logic [NB_CHANNELS-1:0]   cmp;

  assign duty_ready = ~pending_full;

  // Step, wrap and shadow-transfer qualifiers.
  always_comb begin
    step   = tick & enable;
    wrap   = step & (cnt == LAST);
    accept = duty_valid & ~pending_full;
    // While parked there is no period to protect, so a full shadow applies at once.
    load   = pending_full & (wrap | ~enable);
  end

  // Per-channel compare of the shared counter against each active duty.
  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
      cmp[i] = (cnt < active[i*R +: R]);
    end
  end

  // Step counter: advances once per enabled tick, wraps after P-1, parks at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // Shadow and active duty registers; accept and load are mutually exclusive
  // because accept needs the shadow empty and load needs it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      pending_full <= 1'b0;
      active       <= '0;
    end else if (load) begin
      active       <= pending;
      pending_full <= 1'b0;
    end else if (accept) begin
      pending      <= duty_in;
      pending_full <= 1'b1;
    end
  end

  // Registered outputs: PWM levels, period-start pulse and enable edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out     <= '0;
      cycle_start <= 1'b0;
      enable_prev <= 1'b0;
    end else begin
      enable_prev <= enable;
      cycle_start <= wrap | (enable & ~enable_prev);
      pwm_out     <= enable ? cmp : '0;
    end
  end

endmodule

// File: tb/tb_tick_pwm.sv
// Testbench for tick_pwm (R=4, two channels, P=15). Stimulus pushes timestamped
// expectations into a scoreboard queue; a monitor on the falling edge pops and
// compares each entry in the cycle it names.
module tb_tick_pwm;

  localparam int R  = 4;
  localparam int NB = 2;
  localparam int P  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          enable;
  logic [NB*R-1:0] duty_in;
  logic          duty_valid;
  logic          duty_ready;
  logic [NB-1:0] pwm_out;
  logic          cycle_start;

  always #5 clk = ~clk;

  tick_pwm #(
    .RESOLUTION_BITS(R),
    .NB_CHANNELS(NB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .enable(enable),
    .duty_in(duty_in),
    .duty_valid(duty_valid),
    .duty_ready(duty_ready),
    .pwm_out(pwm_out),
    .cycle_start(cycle_start)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            at;
    string         name;
    bit            cp;
    bit            cc;
    bit            cr;
    logic [NB-1:0] pwm;
    logic          cs;
    logic          rdy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   flush  = 1'b0;

  // Bench-side view of the expected state, set by hand in each test.
  int              k;
  logic [NB*R-1:0] cur;
  bit              pend;
  logic [NB*R-1:0] pend_val;
  bit              en_exp;

  function automatic logic [NB-1:0] want_pwm(input int kk, input logic [NB*R-1:0] dd, input bit en);
    logic [NB-1:0] w;
    w = '0;
    if (en) begin
      for (int i = 0; i < NB; i++) w[i] = (kk < int'(dd[i*R +: R]));
    end
    return w;
  endfunction

  task automatic push(input int at, input string name, input bit cp, input bit cc, input bit cr,
                      input logic [NB-1:0] p, input logic c, input logic r);
    exp_t e;
    int   idx;
    e.at = at; e.name = name; e.cp = cp; e.cc = cc; e.cr = cr;
    e.pwm = p; e.cs = c; e.rdy = r;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].at > at) idx--;
    sb.insert(idx, e);
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.at < cyc) begin
        checks++; errors++;
        $display("FAIL %s: expectation for cycle %0d not reached (now %0d)", mon_e.name, mon_e.at, cyc);
      end else begin
        if (mon_e.cp) begin
          checks++;
          if (pwm_out !== mon_e.pwm) begin
            errors++;
            $display("FAIL %s: cycle %0d pwm_out got %b want %b", mon_e.name, cyc, pwm_out, mon_e.pwm);
          end
        end
        if (mon_e.cc) begin
          checks++;
          if (cycle_start !== mon_e.cs) begin
            errors++;
            $display("FAIL %s: cycle %0d cycle_start got %b want %b", mon_e.name, cyc, cycle_start, mon_e.cs);
          end
        end
        if (mon_e.cr) begin
          checks++;
          if (duty_ready !== mon_e.rdy) begin
            errors++;
            $display("FAIL %s: cycle %0d duty_ready got %b want %b", mon_e.name, cyc, duty_ready, mon_e.rdy);
          end
        end
      end
    end
    if (flush) begin
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checks++; errors++;
        $display("FAIL %s: expectation for cycle %0d never checked", mon_e.name, mon_e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One enabled tick followed by 'gap' idle clocks. Checks the 1-clk lag of
  // pwm_out, the cycle_start pulse after a wrap and duty_ready.
  task automatic tick_step(input int gap, input string tag);
    int              n;
    int              k_old;
    logic [NB*R-1:0] d_old;
    bit              wrapped;
    n = cyc; k_old = k; d_old = cur;
    tick = 1'b1;
    wrapped = (k == P-1);
    k = wrapped ? 0 : k + 1;
    if (wrapped && pend) begin
      cur  = pend_val;
      pend = 1'b0;
    end
    push(n+1, {tag, "/lag"}, 1, 1, 1, want_pwm(k_old, d_old, en_exp), wrapped, !pend);
    clk1();
    tick = 1'b0;
    if (gap > 0) push(n+2, {tag, "/step"}, 1, 1, 0, want_pwm(k, cur, en_exp), 1'b0, 1'b0);
    repeat (gap) clk1();
  endtask

  // One-clk write attempt; exp_acc is the hand-decided outcome.
  task automatic write_only(input logic [NB*R-1:0] din, input bit exp_acc, input string tag);
    int n;
    n = cyc;
    duty_valid = 1'b1;
    duty_in    = din;
    if (exp_acc) begin
      pend     = 1'b1;
      pend_val = din;
    end
    push(n+1, tag, 1, 0, 1, want_pwm(k, cur, en_exp), 1'b0, !pend);
    clk1();
    duty_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; tick = 1'b0; enable = 1'b0;
    duty_valid = 1'b1; duty_in = 8'hFF;  // ignored while reset is high
    k = 0; cur = '0; pend = 1'b0; pend_val = '0; en_exp = 1'b0;

    repeat (3) clk1();
    push(cyc, "reset_state", 1, 1, 0, 2'b00, 1'b0, 1'b0);
    reset = 1'b0; duty_valid = 1'b0;
    clk1();
    push(cyc, "post_reset", 1, 1, 1, 2'b00, 1'b0, 1'b1);

    // Enable rise: one cycle_start pulse, counter still at 0.
    n = cyc;
    enable = 1'b1; en_exp = 1'b1;
    push(n+1, "en_rise", 1, 1, 1, 2'b00, 1'b1, 1'b1);
    push(n+2, "en_rise_end", 0, 1, 0, 2'b00, 1'b0, 1'b0);
    clk1(); clk1();

    // Basic duty: ch1=10, ch0=5, written before the first wrap.
    write_only(8'hA5, 1, "t1_wr");
    repeat (30) tick_step(2, "t1");

    // Boundary duties: ch1=15 (always high), ch0=0 (always low) for 3 periods.
    write_only(8'hF0, 1, "t2_wr");
    repeat (15) tick_step(2, "t2_apply");
    repeat (45) tick_step(2, "t2");

    // Shadow update: ch0=5 active, write 12 at cnt=7, blocked second write.
    write_only(8'h35, 1, "t3_wr5");
    repeat (15) tick_step(2, "t3_apply5");
    repeat (7) tick_step(2, "t3_to7");
    write_only(8'h3C, 1, "t3_wr12");
    write_only(8'h39, 0, "t3_wr_blocked");
    repeat (8) tick_step(2, "t3_old_period");
    repeat (15) tick_step(2, "t3_new_period");

    // Four periods with back-to-back ticks.
    repeat (59) tick_step(0, "t4_b2b");
    tick_step(2, "t4_last");

    // Enable gating.
    repeat (9) tick_step(2, "t5_to9");
    n = cyc;
    enable = 1'b0; en_exp = 1'b0; k = 0;
    push(n+1, "t5_disable", 1, 1, 1, 2'b00, 1'b0, 1'b1);
    clk1();
    write_only(8'h72, 1, "t5_wr_disabled");
    n = cyc;
    push(n+1, "t5_apply_no_tick", 1, 1, 1, 2'b00, 1'b0, 1'b1);
    cur = 8'h72; pend = 1'b0;
    clk1();
    for (int i = 0; i < 3; i++) begin
      n = cyc;
      tick = 1'b1;
      push(n+1, "t5_tick_ignored", 1, 1, 1, 2'b00, 1'b0, 1'b1);
      clk1();
      tick = 1'b0;
      clk1();
    end
    n = cyc;
    enable = 1'b1; en_exp = 1'b1;
    push(n+1, "t5_reenable", 1, 1, 1, 2'b11, 1'b1, 1'b1);
    push(n+2, "t5_reenable_end", 1, 1, 0, 2'b11, 1'b0, 1'b0);
    clk1(); clk1();
    repeat (15) tick_step(2, "t5_run");

    // Reset mid-period with pending full; tick and valid during reset are ignored.
    repeat (6) tick_step(2, "t6_to6");
    write_only(8'h9E, 1, "t6_wr");
    n = cyc;
    reset = 1'b1; tick = 1'b1; duty_valid = 1'b1; duty_in = 8'hFF;
    push(n+1, "t6_reset", 1, 1, 1, 2'b00, 1'b0, 1'b1);
    clk1();
    reset = 1'b0; tick = 1'b0; duty_valid = 1'b0;
    k = 0; cur = '0; pend = 1'b0;
    push(n+2, "t6_restart_pulse", 1, 1, 1, 2'b00, 1'b1, 1'b1);
    clk1();
    repeat (16) tick_step(2, "t6_run");

    repeat (3) clk1();
    flush = 1'b1;
    clk1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_pwm.md
Name: tick_pwm

Overview:
- Multi-channel PWM generator clocked by the single-cycle period tick of the team's timer block: one PWM step per tick.
- Sits directly downstream of the timer; its `tick` input is driven by the timer's `start_period` output.
- Duty values are accepted over a valid/ready handshake into a shadow register and applied only at a PWM period boundary, so outputs never glitch mid-period.

Parameters:
- RESOLUTION_BITS, 8, width of step counter and each duty value; PWM period P = 2^RESOLUTION_BITS - 1 ticks.
- NB_CHANNELS, 4, number of independent PWM outputs sharing one step counter.

Ports:
- clk  input  1  system clock; one clock domain only.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  1-clk step strobe from the timer's start_period.
- enable  input  1  run enable; 0 parks the generator.
- duty_in  input  NB_CHANNELS*RESOLUTION_BITS  packed duties; channel i occupies bits [i*R +: R].
- duty_valid  input  1  duty_in is valid this clk.
- duty_ready  output  1  shadow register empty; a write is accepted when valid && ready.
- pwm_out  output  NB_CHANNELS  PWM outputs, registered.
- cycle_start  output  1  1-clk pulse marking the start of a PWM period.

Behaviour:
- Reset values: all internal state and outputs clear on reset, as follows.
  - cnt = 0, active duties = 0, pending empty.
  - duty_ready = 1 from the first clk after reset deasserts.
  - pwm_out = 0, cycle_start = 0.
  - duty_valid is ignored while reset is high.
- Handshake: duty_ready = ~pending_full, driven directly from a register.
  - A write when valid && ready latches duty_in into pending and sets pending_full.
  - While pending_full = 1, writes are not accepted and duty_in is don't-care.
- Counter: cnt (R bits) advances only on clks with tick && enable.
  - Sequence is 0,1,…,P-1, then wraps to 0; the value 2^R-1 is never reached.
- Wrap (edge E, where tick && enable && cnt == P-1):
  - cnt <= 0.
  - If pending_full: active <= pending, pending_full <= 0, so duty_ready is 1 from E+1.
  - cycle_start <= 1 for exactly one clk, in the cycle after E.
- Output: each clk, pwm_out[i] <= (cnt < active[i]); pwm_out therefore lags cnt/active by 1 clk.
  - D = 0 gives constant low; D = P gives constant high; otherwise high for D of P ticks.
- Ticks are spaced at least 2 clks apart by the timer. Back-to-back ticks must still behave per the rules above, with one step per tick.
- enable = 0:
  - cnt forced to 0; pwm_out forced to 0 from the next clk.
  - Pending transfers to active on the first clk it is full (no tick needed), then clears.
  - Ticks are ignored and cycle_start stays 0.
- enable rising 0→1 (registered edge detect): cycle_start pulses in the clk after enable is first sampled 1. The period starts at cnt = 0, and the first tick moves cnt to 1.
- Simultaneous write and wrap: a write cannot land in the wrap clk if pending is already full, because ready is low. If pending is empty at the wrap, the new write lands in pending and applies at the next wrap.
- Reset mid-period takes priority over tick, enable and duty_valid. Any pending duty is discarded.
- All arithmetic is unsigned. The comparison cnt < active is R-bit unsigned. No saturation is needed.

Test Plan:
- Basic duty (R=4, NB_CHANNELS=2, P=15, tick every 3 clks, enable=1): write duties {ch1=10, ch0=5} before the first wrap.
  - ch0 is high for 5 ticks then low for 10; ch1 is high for 10 then low for 5; pattern repeats every 15 ticks.
  - pwm edges lag the counting tick by 1 clk.
- Boundary duties: ch0 = 0 and ch1 = 15 → ch0 constantly 0 and ch1 constantly 1 across 3 full periods, with no glitch at wrap.
- Shadow update: active ch0 = 5; write 12 at cnt = 7.
  - duty_ready drops the next clk; the current period still shows 5 high ticks.
  - The next period shows 12; duty_ready returns to 1 one clk after the wrap tick.
  - A second write attempted while ready = 0 is ignored: the applied value remains 12.
- Cycle_start: count cycle_start pulses over 4 periods → exactly 4 pulses, each 1 clk wide, each asserted the clk after the tick that wrapped 14→0.
- Enable gating:
  - Drop enable at cnt = 9 → pwm_out = 0 next clk and cnt = 0.
  - A pending duty written while disabled applies with no tick.
  - Raise enable → one cycle_start pulse; counting resumes from 0.
- Reset mid-operation: assert reset for 1 clk at cnt = 6 with pending full → next clk: cnt = 0, pwm_out = 0, duty_ready = 1, active = 0, cycle_start = 0.
